// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, FSM states and datapath select encodings for the multicycle control unit
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_I     = 7'd19;
    localparam logic [6:0] OP_BEQ   = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ERROR
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bus between the sequencing FSM and the multicycle datapath
interface multicycle_controller_if;

    logic [6:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       MemReq;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic       InstrDone;
    logic       Illegal;

    modport master (
        input  Op, Zero, MemReady,
        output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, InstrDone, Illegal
    );

    modport slave (
        output Op, Zero, MemReady,
        input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, InstrDone, Illegal
    );

endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - opcode to immediate format and post-DECODE state target
module instr_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src,
    output state_t     decode_next
);

    always_comb begin
        imm_src     = IMM_I;
        decode_next = ERROR;
        case (op)
            OP_LOAD:  begin imm_src = IMM_I; decode_next = MEMADR;   end
            OP_STORE: begin imm_src = IMM_S; decode_next = MEMADR;   end
            OP_R:     begin imm_src = IMM_I; decode_next = EXECUTER; end
            OP_I:     begin imm_src = IMM_I; decode_next = EXECUTEI; end
            OP_BEQ:   begin imm_src = IMM_B; decode_next = BEQ;      end
            OP_JAL:   begin imm_src = IMM_J; decode_next = JAL;      end
            default:  begin imm_src = IMM_I; decode_next = ERROR;    end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - per-instruction state walk driving the shared ALU, memory port and IR
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_controller_if.master bus
);

    state_t state;
    state_t next_state;
    state_t decode_next;
    logic [1:0] imm_src;

    instr_decoder u_instr_decoder (
        .op          (bus.Op),
        .imm_src     (imm_src),
        .decode_next (decode_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (bus.MemReady) next_state = DECODE;
            DECODE:   next_state = decode_next;
            MEMADR:   next_state = (bus.Op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (bus.MemReady) next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWRITE: if (bus.MemReady) next_state = FETCH;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            JAL:      next_state = ALUWB;
            default:  next_state = ERROR;
        endcase
    end

    // Moore decode; only the fetch strobes, the beq PC enable and store retirement look at inputs.
    always_comb begin
        bus.MemReq    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RS2;
        bus.ALUOp     = ALUOP_ADD;
        bus.ResultSrc = RES_ALUOUT;
        bus.InstrDone = 1'b0;
        bus.Illegal   = 1'b0;
        case (state)
            FETCH: begin
                bus.MemReq    = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALU;
                bus.IRWrite   = bus.MemReady;
                bus.PCWrite   = bus.MemReady;
            end
            DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                bus.MemReq = 1'b1;
                bus.AdrSrc = 1'b1;
            end
            MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
                bus.InstrDone = 1'b1;
            end
            MEMWRITE: begin
                bus.MemReq    = 1'b1;
                bus.MemWrite  = 1'b1;
                bus.AdrSrc    = 1'b1;
                bus.InstrDone = bus.MemReady;
            end
            EXECUTER: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUOp   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                bus.RegWrite  = 1'b1;
                bus.InstrDone = 1'b1;
            end
            BEQ: begin
                bus.ALUSrcA   = SRCA_RS1;
                bus.ALUOp     = ALUOP_SUB;
                bus.PCWrite   = bus.Zero;
                bus.InstrDone = 1'b1;
            end
            JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCWrite = 1'b1;
            end
            default: bus.Illegal = 1'b1;
        endcase
    end

    assign bus.ImmSrc = imm_src;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle RV32I core. It replaces the single-cycle main decode with a per-instruction state walk (fetch, decode, execute, memory, writeback) over a shared ALU, a single unified memory port and the instruction/data registers. It supports lw, sw, R-type, I-type ALU, beq and jal, and stalls on a memory ready handshake. ALU function select stays in the existing ALU decoder, which is fed by `ALUOp`.

## Interface
- No parameters; widths fixed by RV32I.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; forces state to FETCH
- `Op`  in  7  opcode field from the instruction register
- `Zero`  in  1  ALU zero flag
- `MemReady`  in  1  memory completes the current access this cycle
- `MemReq`  out  1  memory access request
- `MemWrite`  out  1  store strobe
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `IRWrite`  out  1  load the instruction register and OldPC
- `PCWrite`  out  1  PC enable
- `RegWrite`  out  1  register file write
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- `ALUSrcB`  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4
- `ALUOp`  out  2  00 = add, 01 = sub (compare), 10 = funct decode
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
- `ImmSrc`  out  2  immediate format
- `InstrDone`  out  1  one-cycle pulse when an instruction retires
- `Illegal`  out  1  sticky flag for an unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ERROR.
- Outputs are Moore, decoded from the state, with these exceptions:
  - `PCWrite` and `IRWrite` in FETCH are gated by `MemReady`.
  - `PCWrite` in BEQ equals `Zero`.
  - `ImmSrc` is decoded from `Op`.
  - `InstrDone` is combinational.
- Unlisted outputs are 0 in every state.
- FETCH: `MemReq`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10, `IRWrite`=`PCWrite`=`MemReady`. Holds until `MemReady`, then goes to DECODE.
- DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00 (branch target into ALUOut). Next state by `Op`:
  - 3 or 35 → MEMADR
  - 51 → EXECUTER
  - 19 → EXECUTEI
  - 99 → BEQ
  - 111 → JAL
  - any other → ERROR
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00. Goes to MEMREAD if `Op`=3, else MEMWRITE.
- MEMREAD: `MemReq`=1, `AdrSrc`=1, `ResultSrc`=00. Holds until `MemReady`, then MEMWB.
- MEMWB: `ResultSrc`=01, `RegWrite`=1. Goes to FETCH.
- MEMWRITE: `MemReq`=1, `MemWrite`=1, `AdrSrc`=1, `ResultSrc`=00. Holds until `MemReady`, then FETCH. `MemWrite` stays high for every stalled cycle.
- EXECUTER: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10. Goes to ALUWB.
- EXECUTEI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10. Goes to ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`=1. Goes to FETCH.
- BEQ: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, `PCWrite`=`Zero`. Goes to FETCH.
- JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCWrite`=1. Goes to ALUWB (writes PC+4 to rd).
- ERROR: all strobes 0 and `Illegal`=1. Terminal until reset.
- `ImmSrc` by `Op`, in every state:
  - 3 or 19 → 00
  - 35 → 01
  - 99 → 10
  - 111 → 11
  - others → 00
- `InstrDone`=1 in these cases:
  - MEMWB, ALUWB or BEQ
  - MEMWRITE when `MemReady`=1

## Timing
- Reset is asynchronous: state goes to FETCH immediately; `Illegal` clears.
- While `reset` is high the outputs show FETCH decode; `PCWrite` and `IRWrite` still follow `MemReady`.
- Cycle counts with zero wait states (`MemReady` held at 1):
  - lw 5
  - sw 4
  - R-type and I-type 4
  - beq 3
  - jal 4
- Each cycle of `MemReady`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. No other state samples `MemReady`.
- `Op` is sampled only in DECODE, MEMADR and for `ImmSrc`. `IR` is stable after FETCH.
- Reset mid-instruction: no partial writeback; the next cycle is FETCH.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - opcode constants OP_LOAD=3, OP_STORE=35, OP_R=51, OP_I=19, OP_BEQ=99, OP_JAL=111
  - state enum
  - mux-select localparams (SRCA_*, SRCB_*, RES_*, ALUOP_*)
- Sub-module `instr_decoder`: combinational `Op`→`ImmSrc` and the DECODE next-state target.
- State register plus output decode live in `multicycle_controller`.

## Test plan
- add (`Op`=51), `MemReady`=1 → states FETCH, DECODE, EXECUTER, ALUWB. `RegWrite` high only in cycle 4, `ALUOp`=10 in cycle 3, one `InstrDone` pulse.
- lw (`Op`=3) with `MemReady` low for 2 cycles in MEMREAD → 7 cycles total. `AdrSrc`=1 throughout MEMREAD, `ResultSrc`=01 in MEMWB.
- sw (`Op`=35) with 1 wait cycle → `MemWrite` high for exactly 2 cycles, `RegWrite` never asserted, `InstrDone` in the second MEMWRITE cycle.
- beq (`Op`=99): `Zero`=1 gives `PCWrite`=1 in cycle 3 with `ResultSrc`=00. `Zero`=0 gives `PCWrite`=0 in cycle 3. `ImmSrc`=10 in both cases.
- jal (`Op`=111) → JAL asserts `PCWrite`=1 with `ALUSrcA`=01 and `ALUSrcB`=10, then ALUWB asserts `RegWrite`=1.
- `Op`=7'h7F → ERROR and `Illegal`=1, held 10 cycles with no strobes. Asserting `reset` mid-EXECUTER → FETCH asynchronously with `Illegal`=0.
